// File: rtl/myproject_mac_pkg.sv
// Shared types and default sizing for the dense-layer MAC accumulate/ReLU stage.
package myproject_mac_pkg;

  // Neuron accumulation sequence: waiting for a first beat, summing, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_PROD_WIDTH = 26;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_BIAS_WIDTH = 16;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_FRAC_SHIFT = 10;
  localparam int DEF_N_IN       = 16;
  localparam int DEF_RELU_EN    = 1;

  // The beat counter must be able to hold the value N_IN itself.
  function automatic int cnt_width(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  localparam int DEF_CNT_WIDTH = cnt_width(DEF_N_IN);

endpackage

// File: rtl/myproject_round_relu_sat.sv
// Combinational output formatter: round half up, right shift, optional ReLU,
// then saturate to the signed output range. Works on ACC_WIDTH+1 bits so the
// rounding add can never overflow.
module myproject_round_relu_sat #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int RELU_EN    = 1
) (
  input  logic signed [ACC_WIDTH-1:0] sum_in,
  output logic signed [OUT_WIDTH-1:0] res_out
);

  localparam int EW = ACC_WIDTH + 1;

  logic signed [EW-1:0] sum_ext;
  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] relu_val;
  logic signed [EW-1:0] sat_max;
  logic signed [EW-1:0] sat_min;

  assign sum_ext = {sum_in[ACC_WIDTH-1], sum_in};

  // Largest and smallest representable output values, widened to EW bits.
  assign sat_max = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  assign sat_min = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  generate
    if (FRAC_SHIFT == 0) begin : g_no_shift
      // No fractional bits to drop, so no rounding either.
      assign rounded = sum_ext;
    end else begin : g_shift
      logic signed [EW-1:0] half;
      logic signed [EW-1:0] biased;
      assign half    = {{(EW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
      assign biased  = sum_ext + half;
      assign rounded = biased >>> FRAC_SHIFT;
    end
  endgenerate

  // Clamp negatives to zero when ReLU is enabled.
  always_comb begin
    relu_val = rounded;
    if ((RELU_EN != 0) && rounded[EW-1]) begin
      relu_val = '0;
    end
  end

  // Saturate into the signed output range.
  always_comb begin
    res_out = relu_val[OUT_WIDTH-1:0];
    if (relu_val > sat_max) begin
      res_out = sat_max[OUT_WIDTH-1:0];
    end else if (relu_val < sat_min) begin
      res_out = sat_min[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/myproject_mac_acc_relu.sv
// Accumulates N_IN signed products onto a bias for one neuron, then formats
// the sum (round, shift, ReLU, saturate) and holds it on a valid/ready output.
module myproject_mac_acc_relu
  import myproject_mac_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int N_IN       = DEF_N_IN,
  parameter int RELU_EN    = DEF_RELU_EN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic                         in_last,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         len_err
);

  localparam int CNT_W = cnt_width(N_IN);

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                          len_err_q, len_err_d;

  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   base_sum;
  logic signed [ACC_WIDTH-1:0]   beat_sum;
  logic [CNT_W-1:0]              cnt_next;
  logic                          cnt_full;
  logic                          beat_final;
  logic                          len_bad;
  logic signed [OUT_WIDTH-1:0]   formatted;

  assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};

  // The first beat of a neuron starts from the bias; later beats add onto the running sum.
  always_comb begin
    base_sum = acc_q;
    cnt_next = cnt_q + CNT_W'(1);
    if (state_q == IDLE) begin
      base_sum = bias_ext;
      cnt_next = CNT_W'(1);
    end
  end

  assign beat_sum   = base_sum + prod_ext;
  assign cnt_full   = (cnt_next == CNT_W'(N_IN));
  assign beat_final = in_last || cnt_full;
  // A neuron is malformed when in_last and the N_IN-th beat do not coincide.
  assign len_bad    = in_last != cnt_full;

  // The formatter sees the sum including the current beat, so the result is
  // registered on the same edge that accepts the final beat.
  myproject_round_relu_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_round_relu_sat (
    .sum_in  (beat_sum),
    .res_out (formatted)
  );

  // Next-state logic: accept beats in IDLE/ACC, release the held result in HOLD.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    len_err_d   = len_err_q;
    if (ce) begin
      case (state_q)
        IDLE, ACC: begin
          if (in_valid) begin
            acc_d = beat_sum;
            cnt_d = cnt_next;
            if (len_bad) begin
              len_err_d = 1'b1;
            end
            if (beat_final) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
              out_data_d  = formatted;
            end else begin
              state_d = ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset; a reset drops any partial or pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      len_err_q   <= len_err_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_myproject_mac_acc_relu.sv
// Directed bench: two instances (ReLU on / ReLU off) share one stimulus stream.
module tb_myproject_mac_acc_relu;

  logic               clk;
  logic               reset;
  logic               ce;
  logic               in_valid;
  logic signed [25:0] in_data;
  logic               in_last;
  logic signed [15:0] bias;
  logic               out_ready;

  logic               in_ready_r, out_valid_r, len_err_r;
  logic signed [15:0] out_data_r;
  logic               in_ready_n, out_valid_n, len_err_n;
  logic signed [15:0] out_data_n;

  int total = 0;
  int bad   = 0;
  logic signed [15:0] held;

  myproject_mac_acc_relu #(
    .PROD_WIDTH(26), .ACC_WIDTH(32), .BIAS_WIDTH(16), .OUT_WIDTH(16),
    .FRAC_SHIFT(10), .N_IN(4), .RELU_EN(1)
  ) dut_r (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .in_last(in_last), .bias(bias), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_data(out_data_r), .len_err(len_err_r)
  );

  myproject_mac_acc_relu #(
    .PROD_WIDTH(26), .ACC_WIDTH(32), .BIAS_WIDTH(16), .OUT_WIDTH(16),
    .FRAC_SHIFT(10), .N_IN(4), .RELU_EN(0)
  ) dut_n (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_data(in_data), .in_last(in_last), .bias(bias), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_data(out_data_n), .len_err(len_err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int d, input logic l);
    in_valid = 1'b1;
    in_data  = 26'(d);
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Sends beats d0..d(n-1); in_last on the final beat when use_last is set.
  // Checks out_valid is low before the final edge and high right after it.
  task automatic vec(input string tag, input int b, input int d0, input int d1,
                     input int d2, input int d3, input int n, input bit use_last);
    int d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bias = 16'(b);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk({tag, "_pre_valid"}, 32'(out_valid_r), 32'sd0);
      beat(d[i], (i == n - 1) && use_last);
    end
    chk({tag, "_valid_r"}, 32'(out_valid_r), 32'sd1);
    chk({tag, "_valid_n"}, 32'(out_valid_n), 32'sd1);
    $display("vector %s sent: %0d beats, out_r=%0d out_n=%0d", tag, n, out_data_r, out_data_n);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid_r), 32'sd0);
    chk({tag, "_ready_back"}, 32'(in_ready_r), 32'sd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    bias = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid_r), 32'sd0);
    chk("rst_out_data",  32'(out_data_r),  32'sd0);
    chk("rst_in_ready",  32'(in_ready_r),  32'sd1);
    chk("rst_len_err",   32'(len_err_r),   32'sd0);

    // 1. Basic: 10240 -> (10240+512)>>10 = 10
    vec("basic", 0, 1024, 2048, 3072, 4096, 4, 1'b1);
    chk("basic_data_r", 32'(out_data_r), 32'sd10);
    chk("basic_data_n", 32'(out_data_n), 32'sd10);
    chk("basic_len_err", 32'(len_err_r), 32'sd0);
    chk("basic_in_ready", 32'(in_ready_r), 32'sd0);

    // 4a. Backpressure: hold for 5 cycles while a stray beat is offered.
    in_valid = 1'b1; in_data = 26'(999);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid",    32'(out_valid_r), 32'sd1);
      chk("bp_data",     32'(out_data_r),  32'sd10);
      chk("bp_in_ready", 32'(in_ready_r),  32'sd0);
    end
    in_valid = 1'b0; in_data = '0;
    take("basic");

    // 2. Rounding: (512+512)>>10 = 1; (511+512)>>10 = 0; (-1536+512)>>>10 = -1
    vec("round_up", 512, 0, 0, 0, 0, 4, 1'b1);
    chk("round_up_data", 32'(out_data_n), 32'sd1);
    take("round_up");
    vec("round_dn", 511, 0, 0, 0, 0, 4, 1'b1);
    chk("round_dn_data", 32'(out_data_n), 32'sd0);
    take("round_dn");
    vec("round_neg", -1536, 0, 0, 0, 0, 4, 1'b1);
    chk("round_neg_n", 32'(out_data_n), -32'sd1);
    chk("round_neg_r", 32'(out_data_r), 32'sd0);
    take("round_neg");

    // 3. ReLU: -5000 -> -5 without ReLU, 0 with ReLU
    vec("relu", 0, -1250, -1250, -1250, -1250, 4, 1'b1);
    chk("relu_r", 32'(out_data_r), 32'sd0);
    chk("relu_n", 32'(out_data_n), -32'sd5);
    take("relu");
    // Positive saturation
    vec("sat_pos", 0, 33554431, 33554431, 33554431, 33554431, 4, 1'b1);
    chk("sat_pos_r", 32'(out_data_r), 32'sd32767);
    chk("sat_pos_n", 32'(out_data_n), 32'sd32767);
    take("sat_pos");
    // Negative saturation
    vec("sat_neg", 0, -33554432, -33554432, -33554432, -33554432, 4, 1'b1);
    chk("sat_neg_n", 32'(out_data_n), -32'sd32768);
    chk("sat_neg_r", 32'(out_data_r), 32'sd0);
    take("sat_neg");

    // 4b. ce low for 3 cycles mid-vector with a beat offered: nothing accepted.
    bias = 16'sd0;
    beat(1024, 1'b0);
    beat(2048, 1'b0);
    ce = 1'b0; in_valid = 1'b1; in_data = 26'(7777);
    repeat (3) @(posedge clk);
    #1;
    chk("ce_in_ready", 32'(in_ready_r), 32'sd1);
    chk("ce_no_valid", 32'(out_valid_r), 32'sd0);
    in_valid = 1'b0; in_data = '0; ce = 1'b1;
    beat(3072, 1'b0);
    beat(4096, 1'b1);
    chk("ce_valid", 32'(out_valid_r), 32'sd1);
    chk("ce_data",  32'(out_data_r),  32'sd10);
    $display("vector ce_stall sent: 4 beats, out_r=%0d", out_data_r);
    // ce low while out_ready is high: result must stay put.
    held = out_data_r;
    ce = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ce_hold_valid", 32'(out_valid_r), 32'sd1);
    chk("ce_hold_data",  32'(out_data_r),  32'(held));
    out_ready = 1'b0; ce = 1'b1;
    take("ce_stall");

    // 5a. Early in_last on beat 2: 2048 -> 2, len_err set.
    vec("early_last", 0, 1024, 1024, 0, 0, 2, 1'b1);
    chk("early_data", 32'(out_data_r), 32'sd2);
    chk("early_len_err", 32'(len_err_r), 32'sd1);
    take("early_last");
    // len_err stays set across a well-formed vector.
    vec("sticky", 0, 1024, 1024, 1024, 1024, 4, 1'b1);
    chk("sticky_len_err", 32'(len_err_r), 32'sd1);
    take("sticky");
    do_reset();
    chk("clr_len_err", 32'(len_err_r), 32'sd0);

    // 5b. Beat 4 without in_last: still finalizes, len_err set.
    vec("no_last", 0, 1024, 1024, 1024, 1024, 4, 1'b0);
    chk("no_last_data", 32'(out_data_r), 32'sd4);
    chk("no_last_len_err", 32'(len_err_n), 32'sd1);
    take("no_last");

    // 6. Reset mid-ACC after 2 beats discards the partial sum.
    do_reset();
    bias = 16'sd0;
    beat(1024, 1'b0);
    beat(1024, 1'b0);
    do_reset();
    chk("midrst_valid", 32'(out_valid_r), 32'sd0);
    chk("midrst_in_ready", 32'(in_ready_r), 32'sd1);
    vec("after_rst", 0, 1024, 1024, 1024, 1024, 4, 1'b1);
    chk("after_rst_data", 32'(out_data_r), 32'sd4);
    chk("after_rst_len_err", 32'(len_err_r), 32'sd0);
    take("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
